// File: rtl/pc_next_unit.sv
// -----------------------------------------------------------------------------
// pc_next_unit
//
// Registered program counter for the front of the fetch stage. Each cycle the
// next PC is chosen among the sequential increment and three redirect sources
// (trap > jump > branch). A redirect that arrives while the pipeline is stalled
// is held in a one-entry buffer and applied on the first unstalled edge. A trap
// is never buffered: it loads the PC even while stalled.
//
// Parameters:
//   WIDTH     PC / target width in bits
//   INC       sequential increment (1 = word-addressed, 4 = byte-addressed)
//   RESET_PC  PC value loaded by reset
//
// Ports:
//   clk             in   system clock, rising edge
//   rst             in   synchronous reset, active high, beats every other input
//   stall           in   hold the PC this cycle
//   br_valid        in   branch redirect request
//   br_target       in   branch target (ignored unless br_valid)
//   jmp_valid       in   jump redirect request
//   jmp_target      in   jump target (ignored unless jmp_valid)
//   trap_valid      in   trap redirect request, overrides stall
//   trap_target     in   trap vector (ignored unless trap_valid)
//   pc              out  current PC (registered), instruction-memory address
//   pc_plus         out  pc + INC, combinational, wraps modulo 2^WIDTH
//   redirect_taken  out  high for the cycle after pc was loaded from a redirect
//   pending         out  a buffered redirect is waiting for the stall to drop
//   redirect_cnt    out  (only with PCNU_REDIRECT_CNT_EN) saturating 16-bit
//                        count of redirect loads into pc
//
// Build option:
//   PCNU_REDIRECT_CNT_EN  adds the redirect_cnt port and its counter.
//
// Implicit states (no separate state register; derived from stall/pending):
//   state      | meaning
//   RUN        | pending=0, PC advances or takes a redirect
//   HOLD       | stall=1, pending=0, PC held, no redirect buffered yet
//   HOLD_PEND  | stall=1, pending=1, PC held, one redirect buffered
//   HOLD_PEND -> RUN on stall release (buffered redirect applied) or on trap.
// -----------------------------------------------------------------------------

module pc_next_unit #(
    parameter int unsigned           WIDTH    = 32,
    parameter int unsigned           INC      = 1,
    parameter logic [WIDTH-1:0]      RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     br_valid,
    input  logic [WIDTH-1:0]         br_target,
    input  logic                     jmp_valid,
    input  logic [WIDTH-1:0]         jmp_target,
    input  logic                     trap_valid,
    input  logic [WIDTH-1:0]         trap_target,
    output logic [WIDTH-1:0]         pc,
    output logic [WIDTH-1:0]         pc_plus,
    output logic                     redirect_taken,
`ifdef PCNU_REDIRECT_CNT_EN
    output logic [15:0]              redirect_cnt,
`endif
    output logic                     pending
);

    localparam logic [1:0] PRI_NONE = 2'd0;
    localparam logic [1:0] PRI_BR   = 2'd1;
    localparam logic [1:0] PRI_JMP  = 2'd2;
    localparam logic [1:0] PRI_TRAP = 2'd3;

    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    // Registered state
    logic [WIDTH-1:0] r_pc;
    logic             r_redirect_taken;
    logic             r_pending;
    logic [1:0]       r_pend_pri;
    logic [WIDTH-1:0] r_pend_tgt;
`ifdef PCNU_REDIRECT_CNT_EN
    logic [15:0]      r_redirect_cnt;
`endif

    // Next-state values
    logic [WIDTH-1:0] w_pc_nxt;
    logic             w_redirect_taken_nxt;
    logic             w_pending_nxt;
    logic [1:0]       w_pend_pri_nxt;
    logic [WIDTH-1:0] w_pend_tgt_nxt;
`ifdef PCNU_REDIRECT_CNT_EN
    logic [15:0]      w_redirect_cnt_nxt;
`endif

    // Request resolution
    logic [1:0]       w_cur_pri;
    logic [WIDTH-1:0] w_cur_tgt;
    logic             w_take_cur;
    logic             w_eff_valid;
    logic [WIDTH-1:0] w_eff_tgt;
    logic [WIDTH-1:0] w_pc_inc;

    assign w_pc_inc = r_pc + INC_W;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc             <= RESET_PC;
            r_redirect_taken <= 1'b0;
            r_pending        <= 1'b0;
            r_pend_pri       <= PRI_NONE;
            r_pend_tgt       <= '0;
`ifdef PCNU_REDIRECT_CNT_EN
            r_redirect_cnt   <= 16'd0;
`endif
        end else begin
            r_pc             <= w_pc_nxt;
            r_redirect_taken <= w_redirect_taken_nxt;
            r_pending        <= w_pending_nxt;
            r_pend_pri       <= w_pend_pri_nxt;
            r_pend_tgt       <= w_pend_tgt_nxt;
`ifdef PCNU_REDIRECT_CNT_EN
            r_redirect_cnt   <= w_redirect_cnt_nxt;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // Highest-priority valid source this cycle
        w_cur_pri = PRI_NONE;
        w_cur_tgt = '0;
        if (trap_valid) begin
            w_cur_pri = PRI_TRAP;
            w_cur_tgt = trap_target;
        end else if (jmp_valid) begin
            w_cur_pri = PRI_JMP;
            w_cur_tgt = jmp_target;
        end else if (br_valid) begin
            w_cur_pri = PRI_BR;
            w_cur_tgt = br_target;
        end

        // r_pend_pri is PRI_NONE whenever nothing is buffered, so a plain
        // compare covers both the empty and occupied buffer; ties go to the
        // current request.
        w_take_cur  = (w_cur_pri != PRI_NONE) && (w_cur_pri >= r_pend_pri);
        w_eff_valid = w_take_cur || r_pending;
        w_eff_tgt   = w_take_cur ? w_cur_tgt : r_pend_tgt;

        w_pc_nxt             = r_pc;
        w_redirect_taken_nxt = 1'b0;
        w_pending_nxt        = r_pending;
        w_pend_pri_nxt       = r_pend_pri;
        w_pend_tgt_nxt       = r_pend_tgt;

        // A trap always wins the effective compare, so the stalled-trap case
        // falls through the same load path as an unstalled redirect.
        if (!stall || trap_valid) begin
            if (w_eff_valid) begin
                w_pc_nxt             = w_eff_tgt;
                w_redirect_taken_nxt = 1'b1;
                w_pending_nxt        = 1'b0;
                w_pend_pri_nxt       = PRI_NONE;
                w_pend_tgt_nxt       = '0;
            end else begin
                w_pc_nxt = w_pc_inc;
            end
        end else if (w_take_cur) begin
            // Stalled: buffer the request if it does not lose to what is
            // already held; lower-priority requests are dropped.
            w_pending_nxt  = 1'b1;
            w_pend_pri_nxt = w_cur_pri;
            w_pend_tgt_nxt = w_cur_tgt;
        end

`ifdef PCNU_REDIRECT_CNT_EN
        w_redirect_cnt_nxt = r_redirect_cnt;
        if (w_redirect_taken_nxt && (r_redirect_cnt != 16'hFFFF)) begin
            w_redirect_cnt_nxt = r_redirect_cnt + 16'd1;
        end
`endif
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        pc             = r_pc;
        pc_plus        = w_pc_inc;
        redirect_taken = r_redirect_taken;
        pending        = r_pending;
`ifdef PCNU_REDIRECT_CNT_EN
        redirect_cnt   = r_redirect_cnt;
`endif
    end

endmodule

// File: tb/tb_pc_next_unit.sv
module tb_pc_next_unit;

    localparam int unsigned  WIDTH    = 32;
    localparam int unsigned  INC      = 1;
    localparam logic [31:0]  RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        br_valid;
    logic [31:0] br_target;
    logic        jmp_valid;
    logic [31:0] jmp_target;
    logic        trap_valid;
    logic [31:0] trap_target;
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic        redirect_taken;
    logic        pending;
`ifdef PCNU_REDIRECT_CNT_EN
    logic [15:0] redirect_cnt;
`endif

    pc_next_unit #(
        .WIDTH    (WIDTH),
        .INC      (INC),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .br_valid       (br_valid),
        .br_target      (br_target),
        .jmp_valid      (jmp_valid),
        .jmp_target     (jmp_target),
        .trap_valid     (trap_valid),
        .trap_target    (trap_target),
        .pc             (pc),
        .pc_plus        (pc_plus),
        .redirect_taken (redirect_taken),
`ifdef PCNU_REDIRECT_CNT_EN
        .redirect_cnt   (redirect_cnt),
`endif
        .pending        (pending)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a redirect buffer described as (priority, target)
    // requests; the winner of a load is the highest-priority request, with
    // the current cycle's request listed first so it wins ties.
    logic [31:0] m_pc;
    bit          m_pend;
    int          m_pend_pri;
    logic [31:0] m_pend_tgt;
    bit          m_rt;
    int          m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        int          req_pri [2];
        logic [31:0] req_tgt [2];
        bit          src_v   [3];
        logic [31:0] src_t   [3];
        int          win;
        int          best;
        if (rst) begin
            m_pc       = RESET_PC;
            m_pend     = 0;
            m_pend_pri = 0;
            m_pend_tgt = '0;
            m_rt       = 0;
            m_cnt      = 0;
        end else begin
            src_v[0] = br_valid;   src_t[0] = br_target;
            src_v[1] = jmp_valid;  src_t[1] = jmp_target;
            src_v[2] = trap_valid; src_t[2] = trap_target;
            req_pri[0] = 0;
            req_tgt[0] = '0;
            for (int i = 0; i < 3; i++) begin
                if (src_v[i] && (i + 1) > req_pri[0]) begin
                    req_pri[0] = i + 1;
                    req_tgt[0] = src_t[i];
                end
            end
            req_pri[1] = m_pend ? m_pend_pri : 0;
            req_tgt[1] = m_pend_tgt;
            if (!stall || trap_valid) begin
                win  = -1;
                best = 0;
                for (int k = 0; k < 2; k++) begin
                    if (req_pri[k] > best) begin
                        best = req_pri[k];
                        win  = k;
                    end
                end
                if (win >= 0) begin
                    m_pc       = req_tgt[win];
                    m_rt       = 1;
                    m_pend     = 0;
                    m_pend_pri = 0;
                end else begin
                    m_pc = m_pc + 32'(INC);
                    m_rt = 0;
                end
            end else begin
                m_rt = 0;
                if (req_pri[0] > 0 && req_pri[0] >= req_pri[1]) begin
                    m_pend     = 1;
                    m_pend_pri = req_pri[0];
                    m_pend_tgt = req_tgt[0];
                end
            end
            if (m_rt && m_cnt < 65535) m_cnt++;
        end
    endtask

    task automatic step(input bit r, input bit s,
                        input bit b, input logic [31:0] bt,
                        input bit j, input logic [31:0] jt,
                        input bit t, input logic [31:0] tt);
        rst         = r;
        stall       = s;
        br_valid    = b;
        br_target   = bt;
        jmp_valid   = j;
        jmp_target  = jt;
        trap_valid  = t;
        trap_target = tt;
        @(posedge clk);
        model_update();
        #1;
        chk("pc", pc, m_pc);
        chk("pc_plus", pc_plus, m_pc + 32'(INC));
        chk("redirect_taken", {31'b0, redirect_taken}, {31'b0, m_rt});
        chk("pending", {31'b0, pending}, {31'b0, m_pend});
`ifdef PCNU_REDIRECT_CNT_EN
        chk("redirect_cnt", {16'b0, redirect_cnt}, 32'(m_cnt));
`endif
    endtask

    task automatic idle();
        step(0, 0, 0, '0, 0, '0, 0, '0);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0;
        br_valid = 1'b0; br_target = '0;
        jmp_valid = 1'b0; jmp_target = '0;
        trap_valid = 1'b0; trap_target = '0;
        m_pc = '0; m_pend = 0; m_pend_pri = 0; m_pend_tgt = '0; m_rt = 0; m_cnt = 0;

        // Reset and free run
        step(1, 0, 0, '0, 0, '0, 0, '0);
        chk("reset_pc", pc, 32'h0);
        chk("reset_pending", {31'b0, pending}, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            idle();
            chk("free_run_pc", pc, 32'(i));
            chk("free_run_rt", {31'b0, redirect_taken}, 32'h0);
        end
        for (int i = 0; i < 12; i++) idle();
        chk("reach_0x10", pc, 32'h10);

        // Branch and jump together: jump wins
        step(0, 0, 1, 32'h40, 1, 32'h80, 0, '0);
        chk("br_jmp_pc", pc, 32'h80);
        chk("br_jmp_rt", {31'b0, redirect_taken}, 32'h1);
        idle();
        chk("after_jmp_pc", pc, 32'h81);
        chk("after_jmp_rt", {31'b0, redirect_taken}, 32'h0);

        // Stall with buffered branch replaced by a jump
        step(0, 0, 0, '0, 1, 32'h20, 0, '0);
        step(0, 1, 1, 32'h100, 0, '0, 0, '0);
        chk("stall1_pc", pc, 32'h20);
        chk("stall1_pending", {31'b0, pending}, 32'h1);
        step(0, 1, 0, '0, 1, 32'h200, 0, '0);
        step(0, 1, 0, '0, 0, '0, 0, '0);
        chk("stall3_pc", pc, 32'h20);
        idle();
        chk("release_pc", pc, 32'h200);
        chk("release_pending", {31'b0, pending}, 32'h0);

        // Trap overrides stall and clears the buffered branch
        step(0, 1, 1, 32'h300, 0, '0, 0, '0);
        step(0, 1, 0, '0, 0, '0, 1, 32'h8);
        chk("trap_pc", pc, 32'h8);
        chk("trap_pending", {31'b0, pending}, 32'h0);
        chk("trap_rt", {31'b0, redirect_taken}, 32'h1);

        // Wrap-around
        step(0, 0, 0, '0, 1, 32'hFFFF_FFFF, 0, '0);
        chk("wrap_plus", pc_plus, 32'h0);
        idle();
        chk("wrap_pc", pc, 32'h0);

        // Reset during HOLD_PEND discards the buffered target
        step(0, 1, 1, 32'h500, 0, '0, 0, '0);
        step(1, 1, 0, '0, 0, '0, 0, '0);
        chk("rst_pend_pc", pc, RESET_PC);
        chk("rst_pend_pending", {31'b0, pending}, 32'h0);
        idle();
        chk("rst_pend_no_apply", pc, RESET_PC + 32'(INC));

`ifdef PCNU_REDIRECT_CNT_EN
        step(1, 0, 0, '0, 0, '0, 0, '0);
        chk("cnt_reset", {16'b0, redirect_cnt}, 32'h0);
        step(0, 0, 0, '0, 1, 32'h10, 0, '0);
        step(0, 1, 1, 32'h20, 0, '0, 0, '0);
        step(0, 0, 0, '0, 0, '0, 0, '0);
        step(0, 0, 1, 32'h30, 0, '0, 0, '0);
        chk("cnt_three", {16'b0, redirect_cnt}, 32'h3);
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 49) == 0,
                 $urandom_range(0, 9) < 4,
                 $urandom_range(0, 9) < 2, $urandom,
                 $urandom_range(0, 9) < 2, $urandom,
                 $urandom_range(0, 19) < 2, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
